// File: rtl/noc_output_allocator.sv
// Switch allocator for one router output port. It does round-robin arbitration across the
// input ports, holds a wormhole lock for multi-flit packets, and gates grants on downstream credits.
//
//   state  | meaning
//   IDLE   | output free; arbitrate among eligible inputs from rr_ptr upward
//   LOCKED | a multi-flit packet owns the output until its tail flit is sent
module noc_output_allocator #(
    parameter int NUM_INPUTS        = 5,
    parameter int FLIT_BUFFER_DEPTH = 4,
    parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1),
    parameter int IDX_WIDTH         = $clog2(NUM_INPUTS)
) (
    input  logic                    clk_noc,
    input  logic                    rst_noc,
    input  logic [NUM_INPUTS-1:0]   req,
    input  logic [NUM_INPUTS-1:0]   req_is_tail,
    input  logic [NUM_INPUTS-1:0]   disable_turn,
    input  logic                    credit_in,
    output logic [NUM_INPUTS-1:0]   grant,
    output logic                    send,
    output logic                    locked,
    output logic [IDX_WIDTH-1:0]    owner,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    credit_error
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [IDX_WIDTH-1:0]    LAST_IDX   = IDX_WIDTH'(NUM_INPUTS - 1);

    function automatic logic [IDX_WIDTH-1:0] wrap_inc(input logic [IDX_WIDTH-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IDX_WIDTH'(1);
    endfunction

    state_t                  state_q, state_d;
    logic [IDX_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_WIDTH-1:0]    owner_q, owner_d;
    logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
    logic                    credit_error_q, credit_error_d;
    logic [NUM_INPUTS-1:0]   elig;
    logic [NUM_INPUTS-1:0]   grant_d;
    logic                    arb_found;
    logic [IDX_WIDTH-1:0]    arb_idx;
    logic [IDX_WIDTH-1:0]    cand;
    logic                    has_credit;

    assign has_credit = (credit_q != '0);

    // Rotating priority search starting at rr_ptr with wrap-around.
    always_comb begin
        elig      = req & ~disable_turn;
        arb_found = 1'b0;
        arb_idx   = rr_ptr_q;
        cand      = rr_ptr_q;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (!arb_found && elig[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        grant_d  = '0;
        case (state_q)
            IDLE: begin
                if (has_credit && arb_found) begin
                    grant_d[arb_idx] = 1'b1;
                    owner_d          = arb_idx;
                    if (req_is_tail[arb_idx]) begin
                        rr_ptr_d = wrap_inc(arb_idx);
                    end else begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                // The owner already passed the turn check at its head flit.
                if (has_credit && req[owner_q]) begin
                    grant_d[owner_q] = 1'b1;
                    if (req_is_tail[owner_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = wrap_inc(owner_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst_noc) begin
            grant_d = '0;
        end
    end

    assign grant  = grant_d;
    assign send   = |grant_d;
    assign locked = (state_q == LOCKED);
    assign owner  = owner_q;

    always_comb begin
        credit_d       = credit_q;
        credit_error_d = credit_error_q;
        if (send && !credit_in) begin
            credit_d = credit_q - CREDIT_WIDTH'(1);
        end else if (!send && credit_in) begin
            if (credit_q == CREDIT_MAX) begin
                credit_error_d = 1'b1;
            end else begin
                credit_d = credit_q + CREDIT_WIDTH'(1);
            end
        end
    end

    assign credit_count = credit_q;
    assign credit_error = credit_error_q;

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            credit_q       <= CREDIT_MAX;
            credit_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            owner_q        <= owner_d;
            credit_q       <= credit_d;
            credit_error_q <= credit_error_d;
        end
    end

endmodule

// File: tb/tb_noc_output_allocator.sv
// Directed bench for noc_output_allocator. Inputs change on the falling edge, combinational
// outputs are checked 1 time unit later, and registered outputs are checked at the next falling edge.
module tb_noc_output_allocator;

    logic       clk_noc = 1'b0;
    logic       rst_noc;
    logic [4:0] req, req_is_tail, disable_turn;
    logic       credit_in;
    logic [4:0] grant;
    logic       send, locked, credit_error;
    logic [2:0] owner;
    logic [2:0] credit_count;

    int checks = 0;
    int errors = 0;

    always #5 clk_noc = ~clk_noc;

    noc_output_allocator dut (
        .clk_noc      (clk_noc),
        .rst_noc      (rst_noc),
        .req          (req),
        .req_is_tail  (req_is_tail),
        .disable_turn (disable_turn),
        .credit_in    (credit_in),
        .grant        (grant),
        .send         (send),
        .locked       (locked),
        .owner        (owner),
        .credit_count (credit_count),
        .credit_error (credit_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a falling edge and let the combinational outputs settle.
    task automatic drive(input logic [4:0] r, input logic [4:0] t, input logic ci);
        req         = r;
        req_is_tail = t;
        credit_in   = ci;
        #1;
    endtask

    task automatic tick();
        @(negedge clk_noc);
    endtask

    initial begin
        rst_noc      = 1'b1;
        disable_turn = 5'b00000;
        drive(5'b11111, 5'b11111, 1'b0);
        check("rst_grant", grant, 5'b00000);
        check("rst_send", send, 1'b0);
        check("rst_locked", locked, 1'b0);
        check("rst_owner", owner, 3'd0);
        check("rst_credit", credit_count, 3'd4);
        check("rst_cerr", credit_error, 1'b0);
        tick();
        tick();
        rst_noc = 1'b0;
        drive(5'b00000, 5'b11111, 1'b0);
        tick();

        // Single-flit packets from inputs 1 and 2 are granted one per cycle.
        drive(5'b00110, 5'b11111, 1'b0);
        check("rr_g1", grant, 5'b00010);
        check("rr_send1", send, 1'b1);
        tick();
        check("rr_owner1", owner, 3'd1);
        check("rr_cred3", credit_count, 3'd3);
        drive(5'b00110, 5'b11111, 1'b0);
        check("rr_g2", grant, 5'b00100);
        tick();
        check("rr_cred2", credit_count, 3'd2);
        // Pointer now sits at 3; the search wraps past 4 to reach 0.
        drive(5'b00011, 5'b11111, 1'b0);
        check("rr_wrap_g0", grant, 5'b00001);
        tick();
        check("rr_owner0", owner, 3'd0);
        for (int i = 0; i < 3; i++) begin
            drive(5'b00000, 5'b11111, 1'b1);
            tick();
        end
        check("ret_cred4", credit_count, 3'd4);
        check("ret_cerr0", credit_error, 1'b0);

        // A 3-flit packet on input 2 holds the output against input 4 (pointer is 1).
        drive(5'b10100, 5'b10000, 1'b0);
        check("pkt_head", grant, 5'b00100);
        tick();
        check("pkt_lock1", locked, 1'b1);
        drive(5'b10100, 5'b10000, 1'b0);
        check("pkt_body", grant, 5'b00100);
        tick();
        check("pkt_lock2", locked, 1'b1);
        drive(5'b10100, 5'b10100, 1'b0);
        check("pkt_tail", grant, 5'b00100);
        tick();
        check("pkt_unlock", locked, 1'b0);
        check("pkt_cred1", credit_count, 3'd1);
        drive(5'b10000, 5'b10000, 1'b0);
        check("pkt_g4", grant, 5'b10000);
        tick();
        check("pkt_owner4", owner, 3'd4);
        check("pkt_cred0", credit_count, 3'd0);

        // No credits: the pending request waits until a credit comes back.
        for (int i = 0; i < 2; i++) begin
            drive(5'b00001, 5'b11111, 1'b0);
            check("nocred_grant", grant, 5'b00000);
            check("nocred_send", send, 1'b0);
            tick();
        end
        drive(5'b00001, 5'b11111, 1'b1);
        check("cin_cycle_grant", grant, 5'b00000);
        tick();
        check("cin_cred1", credit_count, 3'd1);
        drive(5'b00001, 5'b11111, 1'b1);
        check("resume_grant", grant, 5'b00001);
        tick();
        check("send_cin_hold", credit_count, 3'd1);
        for (int i = 0; i < 3; i++) begin
            drive(5'b00000, 5'b11111, 1'b1);
            tick();
        end
        check("ret2_cred4", credit_count, 3'd4);

        // A disabled turn is never granted (pointer is 1).
        disable_turn = 5'b00010;
        for (int i = 0; i < 10; i++) begin
            drive(5'b00010, 5'b11111, 1'b0);
            check("dis_nogrant", grant, 5'b00000);
            tick();
        end
        drive(5'b00011, 5'b11111, 1'b0);
        check("dis_g0", grant, 5'b00001);
        tick();
        disable_turn = 5'b00000;
        drive(5'b00000, 5'b11111, 1'b1);
        tick();
        check("ret3_cred4", credit_count, 3'd4);

        // Bubble inside a locked packet on input 3 while input 0 waits (pointer is 1).
        drive(5'b01001, 5'b00001, 1'b0);
        check("bub_head", grant, 5'b01000);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(5'b00001, 5'b00001, 1'b0);
            check("bub_nogrant", grant, 5'b00000);
            tick();
            check("bub_locked", locked, 1'b1);
        end
        drive(5'b01001, 5'b00001, 1'b0);
        check("bub_resume", grant, 5'b01000);
        tick();
        drive(5'b01001, 5'b01001, 1'b0);
        check("bub_tail", grant, 5'b01000);
        tick();
        check("bub_unlock", locked, 1'b0);
        drive(5'b00001, 5'b00001, 1'b0);
        check("bub_g0", grant, 5'b00001);
        tick();
        check("bub_cred0", credit_count, 3'd0);
        for (int i = 0; i < 4; i++) begin
            drive(5'b00000, 5'b11111, 1'b1);
            tick();
        end
        check("ret4_cred4", credit_count, 3'd4);
        check("ret4_cerr0", credit_error, 1'b0);

        // A credit returned while the counter is full saturates the counter and raises a sticky error.
        drive(5'b00000, 5'b11111, 1'b1);
        tick();
        check("ovf_cred4", credit_count, 3'd4);
        check("ovf_cerr", credit_error, 1'b1);
        drive(5'b00000, 5'b11111, 1'b0);
        tick();
        check("ovf_sticky", credit_error, 1'b1);

        // Reset asserted in the middle of a packet (pointer is 1).
        drive(5'b00100, 5'b00000, 1'b0);
        check("mid_head", grant, 5'b00100);
        tick();
        check("mid_locked", locked, 1'b1);
        check("mid_owner2", owner, 3'd2);
        rst_noc = 1'b1;
        drive(5'b00100, 5'b00000, 1'b0);
        check("mrst_locked", locked, 1'b0);
        check("mrst_cred", credit_count, 3'd4);
        check("mrst_cerr", credit_error, 1'b0);
        check("mrst_grant", grant, 5'b00000);
        check("mrst_send", send, 1'b0);
        check("mrst_owner", owner, 3'd0);
        tick();
        check("mrst_grant2", grant, 5'b00000);
        rst_noc = 1'b0;
        drive(5'b00100, 5'b00100, 1'b0);
        check("post_rst_g2", grant, 5'b00100);
        tick();
        check("post_rst_idle", locked, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
